// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate generator with valid/ready skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      instr_31_7_i,
  input  logic [2:0]       imm_src_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  logic [24:0]      b;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_in;
  logic             ill_in;
  logic             acc;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;
  assign b = instr_31_7_i;
  always_comb begin
    imm32 = imm_src_i == 3'd0 ? {{20{b[24]}}, b[24:13]} :
            imm_src_i == 3'd1 ? {{20{b[24]}}, b[24:18], b[4:0]} :
            imm_src_i == 3'd2 ? {{19{b[24]}}, b[24], b[0], b[23:18], b[4:1], 1'b0} :
            imm_src_i == 3'd3 ? {b[24:5], 12'd0} :
            imm_src_i == 3'd4 ? {{11{b[24]}}, b[24], b[12:5], b[13], b[23:14], 1'b0} :
            imm_src_i == 3'd5 ? (XLEN == 64 ? {26'd0, b[18:13]} : {27'd0, b[17:13]}) :
            imm_src_i == 3'd6 ? {27'd0, b[12:8]} : 32'd0;
    ill_in = &imm_src_i;
    imm_in = XLEN'($signed(imm32));
    acc    = in_valid_i && in_ready_o && !flush_i;
  end
  // in_ready_o is registered as !skid_valid so out_ready_i never reaches it combinationally
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      imm_ext_o   <= '0;
      illegal_o   <= 1'b0;
      tag_o       <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_ill    <= 1'b0;
      skid_tag    <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_o  <= 1'b1;
    end else if (!out_valid_o || out_ready_i) begin
      out_valid_o <= skid_valid || acc;
      if (skid_valid) begin
        imm_ext_o <= skid_imm;
        illegal_o <= skid_ill;
        tag_o     <= skid_tag;
      end else if (acc) begin
        imm_ext_o <= imm_in;
        illegal_o <= ill_in;
        tag_o     <= tag_i;
      end
      if (acc) begin
        skid_imm <= imm_in;
        skid_ill <= ill_in;
        skid_tag <= tag_i;
      end
      skid_valid <= skid_valid && acc;
      in_ready_o <= !(skid_valid && acc);
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_in;
      skid_ill   <= ill_in;
      skid_tag   <= tag_i;
      in_ready_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors, handshake sequences and random traffic against a FIFO reference model
module tb_imm_gen_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [31:0] ins = 0;
  logic [2:0]  src = 0;
  logic [7:0]  tag = 0;
  logic        ir32, ov32, il32, ir64, ov64, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tg32, tg64;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [63:0] e64;
    logic [31:0] e32;
    logic        ill;
    logic [7:0]  tag;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [63:0] e64;
    logic [31:0] e32;
    logic        ill;
  } vec_t;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir32),
    .instr_31_7_i(ins[31:7]), .imm_src_i(src), .tag_i(tag), .out_valid_o(ov32),
    .out_ready_i(out_ready), .imm_ext_o(imm32), .illegal_o(il32), .tag_o(tg32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir64),
    .instr_31_7_i(ins[31:7]), .imm_src_i(src), .tag_i(tag), .out_valid_o(ov64),
    .out_ready_i(out_ready), .imm_ext_o(imm64), .illegal_o(il64), .tag_o(tg64));

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Immediates straight from the ISA field definitions on the full 32-bit instruction
  function automatic logic [63:0] model(logic [31:0] i, logic [2:0] s, bit x64);
    longint v;
    case (s)
      3'd0: v = longint'($signed(i[31:20]));
      3'd1: v = longint'($signed({i[31:25], i[11:7]}));
      3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3: v = longint'($signed({i[31:12], 12'd0}));
      3'd4: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd5: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'd0, v[31:0]};
  endfunction

  task automatic check_state();
    chk("ovalid32", 64'(ov32), 64'(q.size() > 0));
    chk("ovalid64", 64'(ov64), 64'(q.size() > 0));
    chk("iready32", 64'(ir32), 64'(q.size() < 2));
    chk("iready64", 64'(ir64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), 64'(q[0].e32));
      chk("imm64", imm64, q[0].e64);
      chk("ill32", 64'(il32), 64'(q[0].ill));
      chk("ill64", 64'(il64), 64'(q[0].ill));
      chk("tag32", 64'(tg32), 64'(q[0].tag));
      chk("tag64", 64'(tg64), 64'(q[0].tag));
    end
  endtask

  task automatic step();
    bit   acc, cons;
    ent_t e;
    acc   = in_valid && q.size() < 2 && !flush;
    cons  = q.size() > 0 && out_ready;
    e.e64 = model(ins, src, 1);
    e.e32 = model(ins, src, 0);
    e.ill = (src == 3'd7);
    e.tag = tag;
    if (cons) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back(e);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic put(logic [7:0] t, logic [2:0] s, logic [31:0] i);
    in_valid = 1;
    tag = t;
    src = s;
    ins = i;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd0, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{3'd2, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0};
    vecs[2] = '{3'd3, 32'h123450B7, 64'h0000000012345000, 32'h12345000, 1'b0};
    vecs[3] = '{3'd3, 32'h800000B7, 64'hFFFFFFFF80000000, 32'h80000000, 1'b0};
    vecs[4] = '{3'd5, 32'h02109093, 64'h21, 32'h1, 1'b0};
    vecs[5] = '{3'd7, 32'h02109093, 64'h0, 32'h0, 1'b1};
    vecs[6] = '{3'd1, 32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 1'b0};
    vecs[7] = '{3'd4, 32'h0080006F, 64'h8, 32'h8, 1'b0};
    vecs[8] = '{3'd6, 32'h300FD073, 64'h1F, 32'h1F, 1'b0};
    vecs[9] = '{3'd0, 32'h7FF00093, 64'h7FF, 32'h7FF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 64'(ov32 | ov64), 64'd0);
    chk("rst_iready", 64'(ir32 & ir64), 64'd1);
    chk("rst_imm", imm64 | 64'(imm32), 64'd0);
    chk("rst_ill", 64'(il32 | il64), 64'd0);
    chk("rst_tag", 64'(tg32 | tg64), 64'd0);
    #2 rst_n = 1;

    // directed format vectors, one per cycle with the consumer always ready
    out_ready = 1;
    foreach (vecs[k]) begin
      put(8'(k + 8'h40), vecs[k].src, vecs[k].ins);
      step();
      chk("vec_ovalid", 64'(ov32 & ov64), 64'd1);
      chk("vec_imm32", 64'(imm32), 64'(vecs[k].e32));
      chk("vec_imm64", imm64, vecs[k].e64);
      chk("vec_ill", 64'(il32), 64'(vecs[k].ill));
      chk("vec_tag", 64'(tg64), 64'(k + 8'h40));
    end
    in_valid = 0;
    step();

    // backpressure: tags 1,2 buffered, 3 waits
    out_ready = 0;
    put(8'd1, 3'd0, 32'h00100093);
    step();
    put(8'd2, 3'd3, 32'hABCDE0B7);
    step();
    chk("bp_iready_low", 64'(ir32), 64'd0);
    put(8'd3, 3'd2, 32'hFE000EE3);
    step();
    step();
    chk("bp_stall_tag", 64'(tg32), 64'd1);
    chk("bp_stall_imm", 64'(imm32), 64'h1);
    out_ready = 1;
    step();
    chk("bp_order2", 64'(tg32), 64'd2);
    step();
    in_valid = 0;
    step();
    chk("bp_order3", 64'(tg64), 64'd3);
    step();
    chk("bp_empty", 64'(ov32), 64'd0);

    // flush with both entries held and an input presented
    out_ready = 0;
    put(8'h10, 3'd0, 32'h00500093);
    step();
    put(8'h11, 3'd0, 32'h00600093);
    step();
    put(8'h12, 3'd0, 32'h00700093);
    flush = 1;
    step();
    flush = 0;
    chk("fl_ovalid", 64'(ov32 | ov64), 64'd0);
    chk("fl_iready", 64'(ir32 & ir64), 64'd1);
    in_valid = 0;
    out_ready = 1;
    step();
    chk("fl_dropped", 64'(ov32), 64'd0);

    // flush with one entry and in_ready high: input still dropped
    out_ready = 0;
    put(8'h20, 3'd1, 32'hFE112C23);
    step();
    put(8'h21, 3'd4, 32'h0080006F);
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    step();
    chk("fl1_dropped", 64'(ov64), 64'd0);

    // asynchronous reset while an entry is held
    put(8'h55, 3'd0, 32'hFFF00093);
    step();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    q.delete();
    chk("ar_ovalid", 64'(ov32 | ov64), 64'd0);
    chk("ar_tag", 64'(tg32 | tg64), 64'd0);
    chk("ar_iready", 64'(ir32 & ir64), 64'd1);
    #3 rst_n = 1;
    out_ready = 1;
    put(8'h66, 3'd3, 32'h123450B7);
    step();
    chk("ar_resume_tag", 64'(tg32), 64'h66);
    in_valid = 0;
    step();

    // random traffic against the FIFO model
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      ins       = $urandom;
      src       = 3'($urandom_range(0, 7));
      tag       = 8'($urandom);
      step();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It takes instruction bits [31:7] and a format select, and produces an XLEN-wide extended immediate with an illegal-format flag and a pass-through tag. Output is one pipeline stage behind the input, through a valid/ready handshake with a 2-entry skid buffer. It sits between the fetch/decode boundary and the execute-stage operand muxes, and supports RV32I and RV64I immediates plus the CSR zimm form.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (anything else is an elaboration error).
TAG_W, 8, width of the opaque tag carried alongside each immediate (e.g. rd index or ROB id).

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  asynchronous, active-low reset.
flush_i  input  1  discard all buffered entries.
in_valid_i  input  1  input entry valid.
in_ready_o  output  1  block can accept an input entry.
instr_31_7_i  input  25  instruction[31:7].
imm_src_i  input  3  format select.
tag_i  input  TAG_W  tag accompanying the entry.
out_valid_o  output  1  output entry valid.
out_ready_i  input  1  consumer accepts the output entry.
imm_ext_o  output  XLEN  extended immediate.
illegal_o  output  1  imm_src_i was an unsupported encoding.
tag_o  output  TAG_W  tag of the output entry.

Behaviour:
- Reset (async assert, sync release): out_valid_o=0, in_ready_o=1, imm_ext_o=0, illegal_o=0, tag_o=0; skid entry invalid.
- Format decode is combinational on the input; the result is registered. In the formats below, b[n] means instr_31_7_i[n], i.e. instruction bit n+7. "sext" sign-extends to XLEN from bit 31 of the 32-bit form.
  - 000 I: sext of b[24:13].
  - 001 S: sext of {b[24:18], b[4:0]}.
  - 010 B: sext of {b[24], b[0], b[23:18], b[4:1], 0}.
  - 011 U: sext of {b[24:5], 12'b0}. For XLEN=64, bits 63:32 copy b[24].
  - 100 J: sext of {b[24], b[12:5], b[13], b[23:14], 0}.
  - 101 SHAMT: zero-extended b[17:13] when XLEN=32; zero-extended b[18:13] when XLEN=64.
  - 110 ZIMM: zero-extended b[12:8] (instruction[19:15]).
  - 111: imm=0, illegal=1. All other formats give illegal=0.
- Handshake:
  - An input is accepted when in_valid_i && in_ready_o.
  - An output is consumed when out_valid_o && out_ready_i.
  - in_ready_o = !skid_valid, driven from a register so there is no combinational path from out_ready_i.
- Data movement, evaluated per cycle:
  - If the output register is empty, or is consumed this cycle: it loads the skid entry if the skid is valid, else the accepted input, else it becomes empty.
  - If the output register holds and is not consumed: an accepted input goes to the skid.
  - If the skid moves to the output register in the same cycle an input is accepted, the input goes into the skid.
- Latency: accepted at edge N, visible on the outputs after edge N. Throughput is 1 entry/cycle under continuous out_ready_i=1.
- Ordering: strict FIFO. At most 2 entries are held.
- Output stability: while out_valid_o=1 && out_ready_i=0, imm_ext_o, illegal_o and tag_o must not change.
- flush_i has priority over everything else:
  - At the next edge both entries are invalidated.
  - An input presented in the flush cycle is dropped, even if in_ready_o=1.
  - A consumption in the flush cycle still counts as a completed transfer.
- When out_valid_o=0, the data outputs hold their last value; they are not required to be zero.
- Reset asserted mid-stream clears both entries immediately (asynchronously).

Test Plan:
- XLEN=32, imm_src=000, instr_31_7=0x1FFE001 (addi x1,x0,-1), out_ready=1 -> one cycle later out_valid=1, imm_ext=0xFFFFFFFF, illegal=0, tag echoed.
- XLEN=32, imm_src=010, instr_31_7=(0xFE000EE3>>7) (beq -4) -> imm_ext=0xFFFFFFFC. With imm_src=011 and instr 0x123450B7 -> imm_ext=0x12345000.
- XLEN=64: imm_src=011 with instr 0x800000B7 -> imm_ext=0xFFFFFFFF80000000. imm_src=101 with instr 0x02109093 (slli x1,x1,33) -> imm_ext=0x21. imm_src=111 -> imm_ext=0, illegal=1.
- Backpressure: stream tags 1,2,3 back-to-back with out_ready=0.
  - Tags 1 and 2 are held; in_ready drops to 0 after 2 accepts, so tag 3 waits.
  - Raise out_ready: outputs appear in order 1,2,3 on consecutive cycles, and data stays stable while stalled.
- Flush with 2 entries buffered plus in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1; the flushed input never appears on the output.
- Assert rst_n_i low mid-cycle while out_valid=1 -> out_valid=0 and tag_o=0 immediately, without waiting for a clock edge; after release, normal operation resumes with an empty buffer.
